// File: rtl/vote_tally_reporter_if.sv
// Handshake and result bundle between a tally requester and vote_tally_reporter.
// The master drives start and the four counts; the slave returns status and results.
interface vote_tally_reporter_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] cand1_count;
  logic [CNT_W-1:0] cand2_count;
  logic [CNT_W-1:0] cand3_count;
  logic [CNT_W-1:0] cand4_count;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [1:0]       winner_idx;
  logic [CNT_W-1:0] winner_count;
  logic [CNT_W+1:0] total_votes;
  logic             tie;
  logic             no_votes;

  modport master (
    output start, cand1_count, cand2_count, cand3_count, cand4_count,
    input  busy, done, result_valid, winner_idx, winner_count, total_votes, tie, no_votes
  );

  modport slave (
    input  start, cand1_count, cand2_count, cand3_count, cand4_count,
    output busy, done, result_valid, winner_idx, winner_count, total_votes, tie, no_votes
  );
endinterface

// File: rtl/vote_tally_reporter.sv
// Freezes four vote counts on start, scans them one per clock, and reports
// winner, winner count, total, tie and no-votes with a start/done handshake.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for start; results from last tally held
// ST_SCAN   | accumulating snapshot entry idx (0..3), one per clock
// ST_FINISH | publishing results, pulsing done
module vote_tally_reporter #(
  parameter int CNT_W = 8
) (
  input logic                  clock,
  input logic                  reset,
  vote_tally_reporter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FINISH
  } state_t;

  state_t state_q, state_d;

  logic             snap_ld, scan_en, fin_en;
  logic [CNT_W-1:0] snap [4];
  logic [CNT_W-1:0] cur;
  logic [1:0]       idx;
  logic [CNT_W-1:0] best;
  logic [1:0]       best_idx;
  logic             tie_r;
  logic [CNT_W+1:0] total_acc;

  logic             busy_q, done_q, result_valid_q, tie_q, no_votes_q;
  logic [1:0]       winner_idx_q;
  logic [CNT_W-1:0] winner_count_q;
  logic [CNT_W+1:0] total_votes_q;

  assign cur = snap[idx];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    snap_ld = 1'b0;
    scan_en = 1'b0;
    fin_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          snap_ld = 1'b1;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        scan_en = 1'b1;
        if (idx == 2'd3) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        fin_en  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap[0]        <= '0;
      snap[1]        <= '0;
      snap[2]        <= '0;
      snap[3]        <= '0;
      idx            <= '0;
      best           <= '0;
      best_idx       <= '0;
      tie_r          <= 1'b0;
      total_acc      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_valid_q <= 1'b0;
      tie_q          <= 1'b0;
      no_votes_q     <= 1'b0;
      winner_idx_q   <= '0;
      winner_count_q <= '0;
      total_votes_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (snap_ld) begin
        snap[0]        <= bus.cand1_count;
        snap[1]        <= bus.cand2_count;
        snap[2]        <= bus.cand3_count;
        snap[3]        <= bus.cand4_count;
        idx            <= '0;
        best           <= '0;
        best_idx       <= '0;
        tie_r          <= 1'b0;
        total_acc      <= '0;
        busy_q         <= 1'b1;
        result_valid_q <= 1'b0;
      end else if (scan_en) begin
        total_acc <= total_acc + {2'b00, cur};
        idx       <= idx + 2'd1;
        if (idx == 2'd0) begin
          best     <= cur;
          best_idx <= 2'd0;
          tie_r    <= 1'b0;
        end else if (cur > best) begin
          best     <= cur;
          best_idx <= idx;
          tie_r    <= 1'b0;
        end else if (cur == best) begin
          // Keep the earlier index so the lowest candidate wins a tie.
          tie_r <= 1'b1;
        end
      end else if (fin_en) begin
        winner_idx_q   <= best_idx;
        winner_count_q <= best;
        total_votes_q  <= total_acc;
        tie_q          <= tie_r & (best != '0);
        no_votes_q     <= (total_acc == '0);
        done_q         <= 1'b1;
        result_valid_q <= 1'b1;
        busy_q         <= 1'b0;
      end
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = result_valid_q;
  assign bus.winner_idx   = winner_idx_q;
  assign bus.winner_count = winner_count_q;
  assign bus.total_votes  = total_votes_q;
  assign bus.tie          = tie_q;
  assign bus.no_votes     = no_votes_q;

endmodule

// File: tb/tb_vote_tally_reporter.sv
// Self-checking bench for vote_tally_reporter: directed cases plus randomized
// tallies compared against a plain arithmetic reference model.
module tb_vote_tally_reporter;

  localparam int CNT_W = 8;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_mis;

  vote_tally_reporter_if #(.CNT_W(CNT_W)) bus ();

  vote_tally_reporter #(.CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: winner is the first index holding the maximum count.
  task automatic ref_tally(input int c[4], output int w_idx, output int w_cnt,
                           output int total, output int tie, output int nov);
    int mx, n_at_max;
    mx = 0; total = 0; n_at_max = 0; w_idx = 0;
    for (int i = 0; i < 4; i++) begin
      total += c[i];
      if (c[i] > mx) mx = c[i];
    end
    for (int i = 3; i >= 0; i--) begin
      if (c[i] == mx) begin
        n_at_max++;
        w_idx = i;
      end
    end
    w_cnt = mx;
    tie   = (n_at_max > 1 && mx != 0) ? 1 : 0;
    nov   = (total == 0) ? 1 : 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_rv"},    bus.result_valid, 0);
    chk({tag, "_widx"},  bus.winner_idx, 0);
    chk({tag, "_wcnt"},  bus.winner_count, 0);
    chk({tag, "_total"}, bus.total_votes, 0);
    chk({tag, "_tie"},   bus.tie, 0);
    chk({tag, "_nov"},   bus.no_votes, 0);
  endtask

  task automatic run_tally(input int a, input int b, input int c, input int d,
                           input bit disturb, input bit restart);
    int cnt[4];
    int e_idx, e_cnt, e_tot, e_tie, e_nov;
    int k, dones;
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
    ref_tally(cnt, e_idx, e_cnt, e_tot, e_tie, e_nov);

    @(negedge clock);
    bus.cand1_count = a[CNT_W-1:0];
    bus.cand2_count = b[CNT_W-1:0];
    bus.cand3_count = c[CNT_W-1:0];
    bus.cand4_count = d[CNT_W-1:0];
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    k = 0;
    dones = 0;
    chk("busy_after_start", bus.busy, 1);
    chk("rv_cleared", bus.result_valid, 0);
    while (!bus.done && k < 12) begin
      @(negedge clock);
      k++;
      if (disturb) begin
        bus.cand1_count = CNT_W'($urandom);
        bus.cand2_count = CNT_W'($urandom);
        bus.cand3_count = CNT_W'($urandom);
        bus.cand4_count = CNT_W'($urandom);
      end
      if (restart && k == 1) begin
        bus.cand1_count = 8'd200;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
    end
    if (bus.done) dones = 1;
    chk("latency", k, 5);
    chk("winner_idx", bus.winner_idx, e_idx);
    chk("winner_count", bus.winner_count, e_cnt);
    chk("total_votes", bus.total_votes, e_tot);
    chk("tie", bus.tie, e_tie);
    chk("no_votes", bus.no_votes, e_nov);
    chk("rv_set", bus.result_valid, 1);
    chk("busy_clear", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    chk("done_pulses", dones, 1);
    chk("rv_held", bus.result_valid, 1);
    chk("winner_held", bus.winner_idx, e_idx);
  endtask

  initial begin
    int k;
    n_cmp = 0;
    n_mis = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.cand1_count = '0;
    bus.cand2_count = '0;
    bus.cand3_count = '0;
    bus.cand4_count = '0;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;

    run_tally(3, 7, 2, 5, 1'b0, 1'b0);
    run_tally(0, 0, 0, 0, 1'b0, 1'b0);
    run_tally(9, 4, 9, 1, 1'b0, 1'b0);
    run_tally(1, 4, 9, 9, 1'b0, 1'b0);
    run_tally(255, 255, 255, 255, 1'b0, 1'b0);
    run_tally(1, 2, 3, 4, 1'b0, 1'b1);

    // Asynchronous reset partway through a scan.
    @(negedge clock);
    bus.cand1_count = 8'd5;
    bus.cand2_count = 8'd6;
    bus.cand3_count = 8'd7;
    bus.cand4_count = 8'd8;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    k = 0;
    repeat (6) begin
      @(negedge clock);
      if (bus.done) k++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (bus.done) k++;
    end
    chk("no_done_after_abort", k, 0);
    chk("rv_after_abort", bus.result_valid, 0);
    run_tally(2, 2, 0, 0, 1'b0, 1'b0);

    for (int it = 0; it < 30; it++) begin
      if (it % 2 == 0)
        run_tally($urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, 1'b0);
      else
        run_tally($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255), 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
